// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core request/response and RAM port bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          ready;
  logic          we_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_datain;
  logic          mem_en;
  logic [DW-1:0] mem_dataout;

  modport master (
    output req, we_req, addr, wdata, mem_dataout,
    input  ready, rdata, done, err, mem_add, mem_datain, mem_en
  );

  modport slave (
    input  req, we_req, addr, wdata, mem_dataout,
    output ready, rdata, done, err, mem_add, mem_datain, mem_en
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request load/store sequencer with range check in front of a RAM
module mem_access_ctrl #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic rstn,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ERR,
    S_RESP
  } state_t;

  // One extra bit so DEPTH == 2**AW is still representable.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic          err_q;
  logic          oor;
  logic          ready_c;
  logic          done_c;
  logic          err_c;
  logic          mem_en_c;

  assign oor = ({1'b0, bus.addr} >= DEPTH_W);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        we_q    <= bus.we_req;
      end
      if (state == S_RD) begin
        rdata_q <= bus.mem_dataout;
      end
      if (state == S_ERR) begin
        err_q <= 1'b1;
      end else if (state == S_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (oor) begin
            state_nxt = S_ERR;
          end else if (bus.we_req) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_WR:    state_nxt = S_RESP;
      S_RD:    state_nxt = S_RESP;
      S_ERR:   state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // rstn gates the write strobe directly so a reset landing on WR drops the write.
  always_comb begin
    ready_c  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    mem_en_c = 1'b0;
    case (state)
      S_IDLE: ready_c = 1'b1;
      S_WR:   mem_en_c = rstn & we_q;
      S_RESP: begin
        done_c = 1'b1;
        err_c  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.ready      = ready_c;
  assign bus.done       = done_c;
  assign bus.err        = err_c;
  assign bus.mem_en     = mem_en_c;
  assign bus.mem_add    = addr_q;
  assign bus.mem_datain = wdata_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk;
  logic rstn;
  logic ram_init;
  logic [15:0] ram [0:255];
  int tests;
  int fails;
  int en_cnt;

  mem_access_ctrl_if #(.AW(16), .DW(16)) bus ();

  mem_access_ctrl #(.AW(16), .DW(16), .DEPTH(256)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the clock edge; preset to 16'h1000 + address.
  assign bus.mem_dataout = (bus.mem_add < 16'd256) ? ram[bus.mem_add[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h1000 + 16'(i);
    end else if (bus.mem_en && bus.mem_add < 16'd256) begin
      ram[bus.mem_add[7:0]] <= bus.mem_datain;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) en_cnt <= en_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic exp_err, input string tag);
    int budget;
    int en0;
    logic exp_en;
    exp_en = we && !exp_err;
    @(negedge clk);
    budget = 0;
    while (bus.ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.req    = 1'b1;
    bus.we_req = we;
    bus.addr   = a;
    bus.wdata  = d;
    en0 = en_cnt;
    @(negedge clk);
    bus.req = 1'b0;
    chk({tag, "_en"}, 32'(bus.mem_en), 32'(exp_en));
    chk({tag, "_early_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, "_en_cycles"}, 32'(en_cnt - en0), exp_en ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, "_err_clr"}, 32'(bus.err), 32'd0);
    chk({tag, "_ready_again"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int last;
    int nacc;
    int en0;
    logic sw;
    logic [15:0] acc;

    tests = 0;
    fails = 0;
    en_cnt = 0;
    ram_init = 1'b1;
    rstn = 1'b0;
    bus.req = 1'b1;
    bus.we_req = 1'b1;
    bus.addr = 16'h0005;
    bus.wdata = 16'h5555;

    // Reset held for 3 cycles with a write request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
    end
    bus.req = 1'b0;
    rstn = 1'b1;
    ram_init = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_no_write", 32'(en_cnt), 32'd0);

    run_txn(1'b1, 16'h0005, 16'hA5C3, 1'b0, "wr5");
    run_txn(1'b0, 16'h0005, 16'h0000, 1'b0, "rd5");
    chk("rd5_rdata", 32'(bus.rdata), 32'hA5C3);

    run_txn(1'b1, 16'h00FF, 16'h1234, 1'b0, "wrff");
    run_txn(1'b0, 16'h00FF, 16'h0000, 1'b0, "rdff");
    chk("rdff_rdata", 32'(bus.rdata), 32'h1234);
    run_txn(1'b1, 16'h0100, 16'hFFFF, 1'b1, "wr100");
    chk("wr100_rdata_hold", 32'(bus.rdata), 32'h1234);
    run_txn(1'b0, 16'h0000, 16'h0000, 1'b0, "rd0");
    chk("rd0_rdata", 32'(bus.rdata), 32'h1000);

    // req held high, alternating reads of 1 and 2: accepts must be 3 cycles apart.
    @(negedge clk);
    bus.req = 1'b1;
    bus.we_req = 1'b0;
    bus.addr = 16'h0001;
    last = -1;
    nacc = 0;
    sw = 1'b0;
    acc = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (sw) begin
        bus.addr = (bus.addr == 16'h0001) ? 16'h0002 : 16'h0001;
        sw = 1'b0;
      end
      if (bus.done === 1'b1) chk("hold_rdata", 32'(bus.rdata), 32'(16'h1000 + acc));
      if (bus.ready === 1'b1) begin
        if (last >= 0) chk("hold_gap", 32'(i - last), 32'd3);
        last = i;
        nacc++;
        acc = bus.addr;
        sw = 1'b1;
      end
    end
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk("hold_last_done", 32'(bus.done), 32'd1);
    chk("hold_last_rdata", 32'(bus.rdata), 32'h1002);
    chk("hold_accepts", 32'(nacc), 32'd4);
    run_txn(1'b1, 16'h0002, 16'h5555, 1'b0, "wr2");
    chk("wr2_rdata_hold", 32'(bus.rdata), 32'h1002);

    // Reset lands on the WR cycle of a write to address 3.
    @(negedge clk);
    bus.req = 1'b1;
    bus.we_req = 1'b1;
    bus.addr = 16'h0003;
    bus.wdata = 16'hBEEF;
    en0 = en_cnt;
    @(negedge clk);
    bus.req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_done2", 32'(bus.done), 32'd0);
    chk("midrst_no_write", 32'(en_cnt - en0), 32'd0);
    run_txn(1'b0, 16'h0003, 16'h0000, 1'b0, "rd3");
    chk("rd3_rdata", 32'(bus.rdata), 32'h1003);

    run_txn(1'b1, 16'h000A, 16'h7E7E, 1'b0, "wra");
    run_txn(1'b0, 16'h000A, 16'h0000, 1'b0, "rda");
    chk("rda_rdata", 32'(bus.rdata), 32'h7E7E);
    run_txn(1'b0, 16'hFFFF, 16'h0000, 1'b1, "rdffff");
    chk("rdffff_rdata_hold", 32'(bus.rdata), 32'h7E7E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front end between the 16-bit core datapath and the single-port distributed-memory RAM wrapper (address/datain/dataout/write-enable, combinational read, write on clk edge).
- Accepts one read or write request at a time over a req/ready handshake and sequences the RAM write-enable.
- Captures read data into a register and returns a one-cycle done pulse with an error flag.
- Range-checks addresses against the physical RAM depth, so an out-of-range access never reaches the array.

Parameters:
AW, 16, request/RAM address width
DW, 16, data width
DEPTH, 256, number of physical RAM words; valid addresses are 0..DEPTH-1

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  synchronous active-low reset
req  input  1  request valid from core
ready  output  1  controller can accept a request
we_req  input  1  1 = write, 0 = read; sampled on accept
addr  input  AW  word address; sampled on accept
wdata  input  DW  write data; sampled on accept
rdata  output  DW  registered read data
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = address out of range
mem_add  output  AW  to RAM address
mem_datain  output  DW  to RAM write data
mem_en  output  1  to RAM write enable
mem_dataout  input  DW  from RAM combinational read data

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, rdata=0, done=0, err=0, latched addr/wdata/we=0. While rstn=0, mem_en is forced to 0 combinationally.
- Reset mid-operation aborts the transaction:
  - no done is produced;
  - a write whose WR cycle coincides with rstn=0 is not performed.
- FSM states:
  - IDLE: ready=1. On req=1, accept: latch addr, wdata, we_req.
    - addr >= DEPTH -> ERR.
    - else we_req=1 -> WR.
    - else -> RD.
  - WR: mem_en=1 for exactly this cycle; the RAM writes at the end of it. Next state RESP.
  - RD: mem_en=0. At the end of the cycle, rdata <= mem_dataout. Next state RESP.
  - ERR: no RAM access (mem_en=0). Next state RESP with err set.
  - RESP: done=1; err=1 only if entered from ERR. Next state IDLE.
- ready=1 only in IDLE. req while ready=0 is ignored; the core must hold req until it sees ready.
- Latency: accept at edge T -> done high during cycle T+2 -> ready high again in cycle T+3. Throughput is one request per 3 cycles.
- mem_add and mem_datain are driven from the latched registers at all times and are stable through WR/RD/RESP. mem_en is high in WR only.
- Register updates:
  - rdata updates only on a successful read and holds its value across writes and errors.
  - err is cleared with done.
- Width rule: no truncation on range check. The full AW-bit address is compared against DEPTH, so for example 16'h0100 with DEPTH=256 is an error, not an alias to 0.
- Simultaneous events:
  - req in the same cycle as done is not accepted (state is RESP).
  - rstn=0 overrides everything.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with req=1 -> ready=0 is not required, but mem_en=0, done=0, rdata=0, state IDLE. After release, ready=1.
- Write then read: write addr=16'h0005, wdata=16'hA5C3 -> mem_en=1 for exactly one cycle (T+1), done at T+2 with err=0. Then read addr=16'h0005 -> done at T+2, rdata=16'hA5C3, err=0.
- Boundary addresses:
  - write 16'h00FF with 16'h1234, read it back -> 16'h1234.
  - write 16'h0100 with 16'hFFFF -> mem_en never asserts; done with err=1. Reading 16'h0000 afterwards returns its prior value, not 16'hFFFF.
- Hold and ignore: keep req=1 continuously with alternating reads of 16'h0001/16'h0002 -> accepts exactly every 3 cycles. rdata holds between reads; a write interleaved does not change rdata.
- Reset mid-write: accept a write of 16'h0003 <= 16'hBEEF, pull rstn=0 during the WR cycle -> mem_en=0, no done. A subsequent read of 16'h0003 returns the old contents.
- Out-of-range read 16'hFFFF after a good read of 16'h7E7E -> err=1 with done, rdata stays 16'h7E7E.
